// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
//   Shared types for the IF/DM memory arbiter.
//   arb_state_e : arbiter FSM state (idle, or busy on behalf of one owner)
//   arb_owner_e : which requester a grant belongs to
//   DBG_CNT_W   : width of the starvation-count debug output
//   busy_state  : maps an owner to the BUSY state that serves it
// -----------------------------------------------------------------------------
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_BUSY_IF = 2'd1,
      ARB_BUSY_DM = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWNER_IF = 1'b0,
      OWNER_DM = 1'b1
   } arb_owner_e;

   // Debug view of the starvation counter; wide enough for any sane limit.
   localparam int DBG_CNT_W = 8;

   function automatic arb_state_e busy_state(input arb_owner_e owner);
      return (owner == OWNER_DM) ? ARB_BUSY_DM : ARB_BUSY_IF;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles the fetch (IF) port, the data (DM) port, the memory port and the
//   arbiter debug view into one interface.
//   modport slave  : the arbiter's view (requests/memory response in,
//                    grants/responses/memory request out)
//   modport master : the environment's view (fetch, mem-access and memory)
//
// Handshake rules (all ports, sampled on rising clk):
//   * A requester raises *_req_i with stable address/data and holds it until
//     the matching *_gnt_o is seen high in a cycle; *_gnt_o is a one-cycle
//     combinational pulse, so the request is consumed at the end of that cycle.
//     A new request may be presented in the following cycle.
//   * *_rvalid_o is a one-cycle pulse one cycle after the memory completes;
//     *_rdata_o is valid with it and holds its value until the next pulse.
//   * mem_req_o stays high with stable we/addr/wdata until a cycle in which
//     mem_ready_i is high; that cycle completes the access. mem_ready_i is
//     ignored while mem_req_o is low.
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();
   import mem_arb_pkg::*;

   // fetch side
   logic              if_req_i;
   logic [ADDR_W-1:0] if_addr_i;
   logic              if_gnt_o;
   logic              if_rvalid_o;
   logic [DATA_W-1:0] if_rdata_o;
   logic              if_stall_o;

   // data side
   logic              dm_req_i;
   logic              dm_we_i;
   logic [ADDR_W-1:0] dm_addr_i;
   logic [DATA_W-1:0] dm_wdata_i;
   logic              dm_gnt_o;
   logic              dm_rvalid_o;
   logic [DATA_W-1:0] dm_rdata_o;

   // memory side
   logic              mem_req_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic              mem_ready_i;
   logic [DATA_W-1:0] mem_rdata_i;

   // debug view
   arb_state_e           dbg_state;
   logic [DBG_CNT_W-1:0] dbg_starve_cnt;

   modport slave (
      input  if_req_i, if_addr_i,
      input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
      input  mem_ready_i, mem_rdata_i,
      output if_gnt_o, if_rvalid_o, if_rdata_o, if_stall_o,
      output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      output dbg_state, dbg_starve_cnt
   );

   modport master (
      output if_req_i, if_addr_i,
      output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
      output mem_ready_i, mem_rdata_i,
      input  if_gnt_o, if_rvalid_o, if_rdata_o, if_stall_o,
      input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      input  dbg_state, dbg_starve_cnt
   );

endinterface

// File: rtl/mem_arbiter_starve_ctr.sv
// -----------------------------------------------------------------------------
// arb_starve_ctr
//   Saturating count of consecutive arbitrations that IF lost to DM.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   inc        : IF was denied this cycle (saturates at LIMIT)
//   clr        : IF was granted this cycle (clear wins over inc)
//   cnt        : current count
//   at_limit   : count has reached LIMIT, IF must win the next conflict
// -----------------------------------------------------------------------------
module arb_starve_ctr #(
   parameter int LIMIT = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             at_limit
);

   assign at_limit = (cnt >= CNT_W'(LIMIT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !at_limit) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-ported memory between instruction fetch (IF) and the
//   memory-access stage (DM). DM normally wins; after STARVE_LIMIT consecutive
//   IF denials IF wins the next conflict. The winning request is latched and
//   held on the memory port until mem_ready_i; the response is returned to its
//   owner one cycle later.
//   clk, rst_n : clock, asynchronous active-low reset (aborts any access)
//   bus        : mem_arbiter_if.slave -- fetch, data and memory ports plus a
//                debug view of the FSM state and the starvation count.
//                ADDR_W/DATA_W must match the interface instance.
//   Parameters : ADDR_W, DATA_W, STARVE_LIMIT (>= 1)
// -----------------------------------------------------------------------------
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_arbiter_if.slave  bus
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   // FSM
   arb_state_e state_q;
   arb_state_e state_d;

   // arbitration
   arb_owner_e win;
   logic       any_req;
   logic       grant_if;
   logic       grant_dm;
   logic       starve_inc;
   logic       starve_clr;
   logic       starve_hit;
   logic [CNT_W-1:0] starve_cnt;

   // latched memory request
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   // responses
   logic              done_if;
   logic              done_dm;
   logic              if_rvalid_q;
   logic              dm_rvalid_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] dm_rdata_q;

   // ---------------------------------------------------------------------------
   // Winner selection. DM wins unless IF is also asking and has already been
   // turned away STARVE_LIMIT times in a row.
   // ---------------------------------------------------------------------------
   always_comb begin
      any_req = bus.dm_req_i || bus.if_req_i;
      if (bus.dm_req_i && (!bus.if_req_i || !starve_hit)) begin
         win = OWNER_DM;
      end else begin
         win = OWNER_IF;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state and grant pulses. Grants are only issued from IDLE, and
   // are held off while reset is asserted so no output pulses during reset.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      grant_if   = 1'b0;
      grant_dm   = 1'b0;
      starve_inc = 1'b0;
      starve_clr = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (rst_n && any_req) begin
               state_d = busy_state(win);
               if (win == OWNER_DM) begin
                  grant_dm   = 1'b1;
                  // only a real conflict counts as an IF denial
                  starve_inc = bus.if_req_i;
               end else begin
                  grant_if   = 1'b1;
                  starve_clr = 1'b1;
               end
            end
         end
         ARB_BUSY_IF, ARB_BUSY_DM: begin
            if (bus.mem_ready_i) begin
               state_d = ARB_IDLE;
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Starvation counter
   // ---------------------------------------------------------------------------
   arb_starve_ctr #(
      .LIMIT (STARVE_LIMIT),
      .CNT_W (CNT_W)
   ) u_starve_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (starve_inc),
      .clr      (starve_clr),
      .cnt      (starve_cnt),
      .at_limit (starve_hit)
   );

   // ---------------------------------------------------------------------------
   // Request latch: captured on the grant edge and held for the whole access.
   // IF is read-only, so its write enable and write data are forced to zero.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (grant_dm) begin
         we_q    <= bus.dm_we_i;
         addr_q  <= bus.dm_addr_i;
         wdata_q <= bus.dm_wdata_i;
      end else if (grant_if) begin
         we_q    <= 1'b0;
         addr_q  <= bus.if_addr_i;
         wdata_q <= '0;
      end
   end

   // ---------------------------------------------------------------------------
   // Response path: the completing cycle is registered, giving a one-cycle
   // rvalid pulse the cycle after mem_ready_i. rdata holds between pulses.
   // A DM write returns zero rather than whatever the memory drives.
   // ---------------------------------------------------------------------------
   assign done_if = (state_q == ARB_BUSY_IF) && bus.mem_ready_i;
   assign done_dm = (state_q == ARB_BUSY_DM) && bus.mem_ready_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_rvalid_q <= 1'b0;
         dm_rvalid_q <= 1'b0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
      end else begin
         if_rvalid_q <= done_if;
         dm_rvalid_q <= done_dm;
         if (done_if) begin
            if_rdata_q <= bus.mem_rdata_i;
         end
         if (done_dm) begin
            dm_rdata_q <= we_q ? '0 : bus.mem_rdata_i;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.if_gnt_o    = grant_if;
   assign bus.dm_gnt_o    = grant_dm;
   assign bus.if_stall_o  = bus.if_req_i && !grant_if;
   assign bus.if_rvalid_o = if_rvalid_q;
   assign bus.dm_rvalid_o = dm_rvalid_q;
   assign bus.if_rdata_o  = if_rdata_q;
   assign bus.dm_rdata_o  = dm_rdata_q;

   assign bus.mem_req_o   = (state_q != ARB_IDLE);
   assign bus.mem_we_o    = we_q;
   assign bus.mem_addr_o  = addr_q;
   assign bus.mem_wdata_o = wdata_q;

   assign bus.dbg_state      = state_q;
   assign bus.dbg_starve_cnt = DBG_CNT_W'(starve_cnt);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter: a memory responder with programmable
//   ready latency, and one task per scenario with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int LIMIT = 4;

   // ---------------------------------------------------------------------------
   // clock / reset
   // ---------------------------------------------------------------------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_arbiter #(
      .ADDR_W       (AW),
      .DATA_W       (DW),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // scoreboard: {owner is DM, rdata}
   logic [DW:0] exp_q[$];

   // responder controls (written by main process only)
   int ready_dly = 0;
   int pulse_req = 0;

   // ---------------------------------------------------------------------------
   // memory responder: waits ready_dly cycles after seeing mem_req_o, then
   // completes with one mem_ready_i cycle. Also injects stray ready pulses.
   // ---------------------------------------------------------------------------
   logic [DW-1:0] mem_model [logic [AW-1:0]];
   int            wait_cnt  = 0;
   int            pulse_done = 0;

   initial begin
      mem_model[32'h10] = 32'hDEAD_BEEF;
      mem_model[32'h20] = 32'hCAFE_F00D;
      mem_model[32'h30] = 32'h0BAD_C0DE;
      bus.mem_ready_i = 1'b0;
      bus.mem_rdata_i = '0;
      forever begin
         @(posedge clk);
         #1;
         if (pulse_req != pulse_done) begin
            pulse_done      = pulse_req;
            bus.mem_ready_i = 1'b1;
            bus.mem_rdata_i = 32'h5555_AAAA;
            wait_cnt        = 0;
         end else if (bus.mem_req_o && !bus.mem_ready_i) begin
            if (wait_cnt >= ready_dly) begin
               bus.mem_ready_i = 1'b1;
               wait_cnt        = 0;
               if (bus.mem_we_o) begin
                  mem_model[bus.mem_addr_o] = bus.mem_wdata_o;
                  bus.mem_rdata_i = 32'hFFFF_FFFF;
               end else begin
                  bus.mem_rdata_i = mem_model.exists(bus.mem_addr_o) ?
                                    mem_model[bus.mem_addr_o] : '0;
               end
            end else begin
               bus.mem_ready_i = 1'b0;
               wait_cnt++;
            end
         end else begin
            bus.mem_ready_i = 1'b0;
            wait_cnt        = 0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // driver tasks
   // ---------------------------------------------------------------------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.if_req_i   = 1'b0;
      bus.if_addr_i  = '0;
      bus.dm_req_i   = 1'b0;
      bus.dm_we_i    = 1'b0;
      bus.dm_addr_i  = '0;
      bus.dm_wdata_i = '0;
   endtask

   // ---------------------------------------------------------------------------
   // scenarios
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      smp();
      n_checks++;
      if ({bus.mem_req_o, bus.if_gnt_o, bus.dm_gnt_o, bus.if_rvalid_o, bus.dm_rvalid_o} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b want 00000", {bus.mem_req_o, bus.if_gnt_o, bus.dm_gnt_o, bus.if_rvalid_o, bus.dm_rvalid_o});
      end
      n_checks++;
      if ({bus.if_rdata_o, bus.dm_rdata_o} !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_rdata: got %h/%h want 0/0", bus.if_rdata_o, bus.dm_rdata_o);
      end
      n_checks++;
      if (bus.dbg_state !== ARB_IDLE || bus.dbg_starve_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_state: got state %0d cnt %0d want 0 0", bus.dbg_state, bus.dbg_starve_cnt);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_if_read();
      int found;
      ready_dly = 2;
      cyc();
      bus.if_addr_i = 32'h10;
      bus.if_req_i  = 1'b1;
      smp();
      n_checks++;
      if ({bus.if_gnt_o, bus.dm_gnt_o, bus.if_stall_o} !== 3'b100) begin
         n_fail++;
         $display("FAIL if_read_gnt: got gnt/dm/stall %b want 100", {bus.if_gnt_o, bus.dm_gnt_o, bus.if_stall_o});
      end
      cyc();
      bus.if_req_i = 1'b0;
      smp();
      n_checks++;
      if (bus.mem_req_o !== 1'b1 || bus.mem_we_o !== 1'b0 || bus.mem_addr_o !== 32'h10) begin
         n_fail++;
         $display("FAIL if_read_mem: got req %b we %b addr %h want 1 0 10", bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o);
      end
      found = 0;
      for (int k = 2; k <= 12; k++) begin
         cyc();
         smp();
         if (bus.if_rvalid_o) begin
            found = k;
            break;
         end
      end
      n_checks++;
      if (found !== 4) begin
         n_fail++;
         $display("FAIL if_read_latency: got rvalid at cycle %0d want 4", found);
      end
      n_checks++;
      if (bus.if_rdata_o !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL if_read_data: got %h want deadbeef", bus.if_rdata_o);
      end
      cyc();
      smp();
      n_checks++;
      if (bus.if_rvalid_o !== 1'b0 || bus.if_rdata_o !== 32'hDEAD_BEEF || bus.dbg_state !== ARB_IDLE) begin
         n_fail++;
         $display("FAIL if_read_hold: got rvalid %b data %h state %0d want 0 deadbeef 0", bus.if_rvalid_o, bus.if_rdata_o, bus.dbg_state);
      end
   endtask

   task automatic test_dm_write();
      ready_dly = 0;
      cyc();
      bus.dm_req_i   = 1'b1;
      bus.dm_we_i    = 1'b1;
      bus.dm_addr_i  = 32'h40;
      bus.dm_wdata_i = 32'h1234_5678;
      smp();
      n_checks++;
      if ({bus.dm_gnt_o, bus.if_gnt_o} !== 2'b10) begin
         n_fail++;
         $display("FAIL dm_write_gnt: got dm/if %b want 10", {bus.dm_gnt_o, bus.if_gnt_o});
      end
      cyc();
      bus.dm_req_i = 1'b0;
      smp();
      n_checks++;
      if (bus.mem_req_o !== 1'b1 || bus.mem_we_o !== 1'b1 || bus.mem_addr_o !== 32'h40 || bus.mem_wdata_o !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL dm_write_mem: got req %b we %b addr %h wdata %h want 1 1 40 12345678", bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o);
      end
      cyc();
      smp();
      n_checks++;
      if (bus.dm_rvalid_o !== 1'b1 || bus.dm_rdata_o !== 32'h0 || bus.if_rvalid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL dm_write_resp: got rvalid %b rdata %h if_rvalid %b want 1 0 0", bus.dm_rvalid_o, bus.dm_rdata_o, bus.if_rvalid_o);
      end
   endtask

   task automatic test_conflict();
      int found;
      ready_dly = 1;
      cyc();
      bus.if_addr_i = 32'h20;
      bus.if_req_i  = 1'b1;
      bus.dm_we_i   = 1'b0;
      bus.dm_addr_i = 32'h40;
      bus.dm_req_i  = 1'b1;
      smp();
      n_checks++;
      if ({bus.dm_gnt_o, bus.if_gnt_o, bus.if_stall_o} !== 3'b101) begin
         n_fail++;
         $display("FAIL conflict_gnt: got dm/if/stall %b want 101", {bus.dm_gnt_o, bus.if_gnt_o, bus.if_stall_o});
      end
      cyc();
      bus.dm_req_i = 1'b0;
      smp();
      n_checks++;
      if (bus.dbg_starve_cnt !== 8'd1 || bus.if_stall_o !== 1'b1) begin
         n_fail++;
         $display("FAIL conflict_starve: got cnt %0d stall %b want 1 1", bus.dbg_starve_cnt, bus.if_stall_o);
      end
      found = 0;
      for (int k = 2; k <= 15; k++) begin
         cyc();
         smp();
         if (bus.dm_rvalid_o) begin
            found = k;
            break;
         end
      end
      n_checks++;
      if (found !== 3 || bus.if_gnt_o !== 1'b1 || bus.if_stall_o !== 1'b0) begin
         n_fail++;
         $display("FAIL conflict_handover: got rvalid cycle %0d if_gnt %b stall %b want 3 1 0", found, bus.if_gnt_o, bus.if_stall_o);
      end
      n_checks++;
      if (bus.dm_rdata_o !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL conflict_dm_data: got %h want 12345678", bus.dm_rdata_o);
      end
      cyc();
      bus.if_req_i = 1'b0;
      smp();
      n_checks++;
      if (bus.dbg_starve_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL conflict_clr: got cnt %0d want 0", bus.dbg_starve_cnt);
      end
      found = 0;
      for (int k = 0; k < 10; k++) begin
         cyc();
         smp();
         if (bus.if_rvalid_o) begin
            found = 1;
            break;
         end
      end
      n_checks++;
      if (found !== 1 || bus.if_rdata_o !== 32'hCAFE_F00D) begin
         n_fail++;
         $display("FAIL conflict_if_data: got seen %0d data %h want 1 cafef00d", found, bus.if_rdata_o);
      end
   endtask

   task automatic test_starvation();
      arb_owner_e exp_seq [6] = '{OWNER_DM, OWNER_DM, OWNER_DM, OWNER_DM, OWNER_IF, OWNER_DM};
      arb_owner_e seq [6];
      int         grants = 0;
      int         cnt_at_if = -1;
      bit         drop_if = 1'b0;
      int         found;
      ready_dly = 0;
      cyc();
      bus.if_addr_i = 32'h30;
      bus.if_req_i  = 1'b1;
      bus.dm_we_i   = 1'b0;
      bus.dm_addr_i = 32'h40;
      bus.dm_req_i  = 1'b1;
      for (int k = 0; k < 80; k++) begin
         smp();
         if (bus.dm_gnt_o && grants < 6) begin
            seq[grants] = OWNER_DM;
            grants++;
         end
         if (bus.if_gnt_o && grants < 6) begin
            seq[grants] = OWNER_IF;
            cnt_at_if   = int'(bus.dbg_starve_cnt);
            grants++;
            drop_if     = 1'b1;
         end
         if (grants >= 6) break;
         cyc();
         if (drop_if) bus.if_req_i = 1'b0;
      end
      cyc();
      bus.dm_req_i = 1'b0;
      n_checks++;
      if (grants !== 6) begin
         n_fail++;
         $display("FAIL starve_grants: got %0d grants want 6", grants);
      end
      for (int i = 0; i < 6; i++) begin
         if (i < grants) begin
            n_checks++;
            if (seq[i] !== exp_seq[i]) begin
               n_fail++;
               $display("FAIL starve_order[%0d]: got owner %0d want %0d", i, seq[i], exp_seq[i]);
            end
         end
      end
      n_checks++;
      if (cnt_at_if !== LIMIT) begin
         n_fail++;
         $display("FAIL starve_limit: got cnt %0d at IF grant want %0d", cnt_at_if, LIMIT);
      end
      smp();
      n_checks++;
      if (bus.dbg_starve_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL starve_after: got cnt %0d want 0", bus.dbg_starve_cnt);
      end
      found = 0;
      for (int k = 0; k < 10; k++) begin
         if (bus.dm_rvalid_o) begin
            found = 1;
            break;
         end
         cyc();
         smp();
      end
      n_checks++;
      if (found !== 1 || bus.dm_rdata_o !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL starve_drain: got seen %0d data %h want 1 12345678", found, bus.dm_rdata_o);
      end
   endtask

   task automatic test_reset_mid();
      bit stray;
      ready_dly = 6;
      cyc();
      bus.dm_we_i   = 1'b0;
      bus.dm_addr_i = 32'h40;
      bus.dm_req_i  = 1'b1;
      cyc();
      bus.dm_req_i = 1'b0;
      smp();
      n_checks++;
      if (bus.mem_req_o !== 1'b1 || bus.dbg_state !== ARB_BUSY_DM) begin
         n_fail++;
         $display("FAIL rst_mid_busy: got req %b state %0d want 1 2", bus.mem_req_o, bus.dbg_state);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.mem_req_o, bus.mem_we_o, bus.dm_gnt_o, bus.if_gnt_o, bus.dm_rvalid_o, bus.if_rvalid_o} !== 6'b0 || bus.mem_addr_o !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_mid_ctrl: got ctrl %b addr %h want 000000 0", {bus.mem_req_o, bus.mem_we_o, bus.dm_gnt_o, bus.if_gnt_o, bus.dm_rvalid_o, bus.if_rvalid_o}, bus.mem_addr_o);
      end
      n_checks++;
      if (bus.dm_rdata_o !== 32'h0 || bus.if_rdata_o !== 32'h0 || bus.dbg_state !== ARB_IDLE) begin
         n_fail++;
         $display("FAIL rst_mid_data: got dm %h if %h state %0d want 0 0 0", bus.dm_rdata_o, bus.if_rdata_o, bus.dbg_state);
      end
      smp();
      rst_n = 1'b1;
      stray = 1'b0;
      for (int k = 0; k < 10; k++) begin
         cyc();
         smp();
         if (bus.dm_rvalid_o || bus.if_rvalid_o || bus.mem_req_o) stray = 1'b1;
      end
      n_checks++;
      if (stray !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_after: got activity %b after release want 0", stray);
      end
   endtask

   task automatic drive_op(input int i, input bit op_dm [8], input bit op_we [8],
                           input logic [AW-1:0] op_addr [8], input logic [DW-1:0] op_wdata [8]);
      if (i >= 8) begin
         bus.if_req_i = 1'b0;
         bus.dm_req_i = 1'b0;
      end else if (op_dm[i]) begin
         bus.if_req_i   = 1'b0;
         bus.dm_we_i    = op_we[i];
         bus.dm_addr_i  = op_addr[i];
         bus.dm_wdata_i = op_wdata[i];
         bus.dm_req_i   = 1'b1;
      end else begin
         bus.dm_req_i  = 1'b0;
         bus.if_addr_i = op_addr[i];
         bus.if_req_i  = 1'b1;
      end
   endtask

   task automatic test_idle_ready_and_burst();
      bit            op_dm    [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      bit            op_we    [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [AW-1:0] op_addr  [8] = '{32'h10, 32'h200, 32'h20, 32'h200, 32'h30, 32'h204, 32'h10, 32'h204};
      logic [DW-1:0] op_wdata [8] = '{32'h0, 32'h1111_2222, 32'h0, 32'h0, 32'h0, 32'h3333_4444, 32'h0, 32'h0};
      logic [DW-1:0] exp_rd   [8] = '{32'hDEAD_BEEF, 32'h0, 32'hCAFE_F00D, 32'h1111_2222,
                                      32'h0BAD_C0DE, 32'h0, 32'hDEAD_BEEF, 32'h3333_4444};
      int          idx = 0;
      int          n_rv = 0;
      bit          adv = 1'b0;
      bit          done = 1'b0;
      logic [DW:0] got;
      logic [DW:0] want;

      // stray ready while idle
      idle_inputs();
      ready_dly = 0;
      smp();
      pulse_req++;
      cyc();
      smp();
      n_checks++;
      if (bus.dbg_state !== ARB_IDLE || bus.mem_req_o !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_ready_state: got state %0d req %b want 0 0", bus.dbg_state, bus.mem_req_o);
      end
      cyc();
      smp();
      n_checks++;
      if (bus.if_rvalid_o !== 1'b0 || bus.dm_rvalid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_ready_rvalid: got if %b dm %b want 0 0", bus.if_rvalid_o, bus.dm_rvalid_o);
      end

      // burst of alternating requests, each presented right after the last grant
      cyc();
      drive_op(0, op_dm, op_we, op_addr, op_wdata);
      for (int k = 0; k < 150; k++) begin
         smp();
         n_checks++;
         if ((bus.if_gnt_o && bus.dm_gnt_o) || (bus.if_rvalid_o && bus.dm_rvalid_o)) begin
            n_fail++;
            $display("FAIL burst_exclusive: got gnt %b%b rvalid %b%b want one-hot", bus.if_gnt_o, bus.dm_gnt_o, bus.if_rvalid_o, bus.dm_rvalid_o);
         end
         if ((bus.if_gnt_o || bus.dm_gnt_o) && idx < 8) begin
            n_checks++;
            if (bus.dm_gnt_o !== op_dm[idx]) begin
               n_fail++;
               $display("FAIL burst_gnt_side[%0d]: got dm_gnt %b want %b", idx, bus.dm_gnt_o, op_dm[idx]);
            end
            exp_q.push_back({op_dm[idx], exp_rd[idx]});
            idx++;
            adv = 1'b1;
         end
         if (bus.if_rvalid_o || bus.dm_rvalid_o) begin
            n_rv++;
            got = bus.dm_rvalid_o ? {1'b1, bus.dm_rdata_o} : {1'b0, bus.if_rdata_o};
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL burst_unexpected: got owner %b data %h want nothing", got[DW], got[DW-1:0]);
            end else begin
               want = exp_q.pop_front();
               if (got !== want) begin
                  n_fail++;
                  $display("FAIL burst_resp[%0d]: got owner %b data %h want owner %b data %h", n_rv - 1, got[DW], got[DW-1:0], want[DW], want[DW-1:0]);
               end
            end
         end
         if (idx == 8 && exp_q.size() == 0) begin
            done = 1'b1;
            break;
         end
         cyc();
         if (adv) drive_op(idx, op_dm, op_we, op_addr, op_wdata);
         adv = 1'b0;
      end
      idle_inputs();
      n_checks++;
      if (done !== 1'b1 || n_rv !== 8) begin
         n_fail++;
         $display("FAIL burst_complete: got done %b grants %0d responses %0d want 1 8 8", done, idx, n_rv);
      end
   endtask

   // ---------------------------------------------------------------------------
   // watchdog
   // ---------------------------------------------------------------------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // sequence and final report
   // ---------------------------------------------------------------------------
   initial begin
      test_reset();
      test_if_read();
      test_dm_write();
      test_conflict();
      test_starvation();
      test_reset_mid();
      test_idle_ready_and_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
